// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants and GF(2^8) arithmetic
// used by the iterative cipher and its S-box.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYEXP,
      S_INIT,
      S_ROUND,
      S_DONE
   } aes_state_e;

   localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, bb;
      p  = '0;
      x  = a;
      bb = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ x;
         x  = xtime(x);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      return gf_mul(x240, gf_mul(x12, x2));
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   function automatic logic [127:0] mix_state(input logic [127:0] st, input logic inv);
      if (inv)
         return {inv_mix_column(st[127:96]), inv_mix_column(st[95:64]),
                 inv_mix_column(st[63:32]), inv_mix_column(st[31:0])};
      return {mix_column(st[127:96]), mix_column(st[95:64]),
              mix_column(st[63:32]), mix_column(st[31:0])};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box computed from the GF(2^8) inverse and the affine map; INVERSE selects InvSubBytes.
module aes_sbox
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   logic [7:0] w_pre;
   logic [7:0] w_inv;

   always_comb begin
      if (INVERSE)
         w_pre = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                 {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
      else
         w_pre = i_byte;
      w_inv = gf_inv(w_pre);
      if (INVERSE)
         o_byte = w_inv;
      else
         o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                  {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encrypt/decrypt core with on-chip key expansion (one round key per cycle)
// and ROUNDS_PER_CYCLE unrolled rounds per clock.
module aes_cipher_iter
   import aes_pkg::*;
#(
   parameter int unsigned ROUNDS_PER_CYCLE = 1,
   parameter bit          DEC_EN           = 1'b1
) (
   input  logic         clock,
   input  logic         resetModule,
   input  logic [127:0] key,
   input  logic         keyLoadFlag,
   input  logic [127:0] inputData,
   input  logic         modeDecrypt,
   input  logic         inputsLoadedFlag,
   output logic         readyFlag,
   output logic         keyReadyFlag,
   output logic [127:0] outputData,
   output logic         dataDoneFlag
);

   aes_state_e   r_fsm, w_fsm_nxt;
   logic [3:0]   r_round;
   logic         r_keyready, r_done, r_dec;
   logic [127:0] r_out, r_data;
   logic [127:0] r_rk [0:NUM_ROUNDS];

   logic         w_key_acc, w_blk_acc, w_last;
   logic [127:0] w_prev_key, w_next_key, w_round_out;
   logic [31:0]  w_rot, w_temp;
   logic [7:0]   w_ksb [0:3];

   assign w_last = (r_round == 4'(NUM_ROUNDS - ROUNDS_PER_CYCLE + 1));

   // Key expansion: derive rk[r_round] from rk[r_round-1]
   assign w_prev_key = r_rk[r_round - 4'd1];
   assign w_rot      = {w_prev_key[23:0], w_prev_key[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_ksbox
      aes_sbox #(.INVERSE(1'b0)) u_sbox (.i_byte(w_rot[31-8*b -: 8]), .o_byte(w_ksb[b]));
   end

   assign w_temp = {w_ksb[0] ^ RCON[r_round], w_ksb[1], w_ksb[2], w_ksb[3]};
   assign w_next_key[127:96] = w_prev_key[127:96] ^ w_temp;
   assign w_next_key[95:64]  = w_prev_key[95:64]  ^ w_next_key[127:96];
   assign w_next_key[63:32]  = w_prev_key[63:32]  ^ w_next_key[95:64];
   assign w_next_key[31:0]   = w_prev_key[31:0]   ^ w_next_key[63:32];

   // Chained round stages; stage s performs round r_round+s.
   for (genvar s = 0; s < ROUNDS_PER_CYCLE; s++) begin : g_rnd
      logic [127:0] w_in, w_out, w_rk, w_sr, w_pre, w_mix;
      logic [3:0]   w_n;
      logic [7:0]   w_fsb [0:15];
      logic [7:0]   w_isb [0:15];

      if (s == 0) begin : g_first
         assign w_in = r_data;
      end else begin : g_chain
         assign w_in = g_rnd[s-1].w_out;
      end

      assign w_n  = r_round + 4'(s);
      assign w_rk = r_dec ? r_rk[4'(NUM_ROUNDS) - w_n] : r_rk[w_n];

      for (genvar b = 0; b < 16; b++) begin : g_byte
         aes_sbox #(.INVERSE(1'b0)) u_fwd (.i_byte(w_in[127-8*b -: 8]), .o_byte(w_fsb[b]));
         if (DEC_EN) begin : g_inv
            aes_sbox #(.INVERSE(1'b1)) u_inv (.i_byte(w_in[127-8*b -: 8]), .o_byte(w_isb[b]));
         end else begin : g_noinv
            assign w_isb[b] = '0;
         end
      end

      // Byte substitution commutes with the row shift, so both directions substitute first.
      for (genvar c = 0; c < 4; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[127-8*(4*c+r) -: 8] = r_dec ? w_isb[4*((c+4-r)%4)+r]
                                                    : w_fsb[4*((c+r)%4)+r];
         end
      end

      always_comb begin
         w_pre = r_dec ? (w_sr ^ w_rk) : w_sr;
         w_mix = mix_state(w_pre, r_dec);
         w_out = (w_n == 4'(NUM_ROUNDS)) ? w_pre : w_mix;
         if (!r_dec) w_out = w_out ^ w_rk;
      end
   end

   assign w_round_out = g_rnd[ROUNDS_PER_CYCLE-1].w_out;

   always_comb begin
      w_fsm_nxt = r_fsm;
      w_key_acc = 1'b0;
      w_blk_acc = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            w_key_acc = keyLoadFlag;
            w_blk_acc = !keyLoadFlag && inputsLoadedFlag && r_keyready;
            if (w_key_acc)      w_fsm_nxt = S_KEYEXP;
            else if (w_blk_acc) w_fsm_nxt = S_INIT;
         end
         S_KEYEXP: if (r_round == 4'(NUM_ROUNDS)) w_fsm_nxt = S_IDLE;
         S_INIT:   w_fsm_nxt = S_ROUND;
         S_ROUND:  if (w_last) w_fsm_nxt = S_DONE;
         S_DONE:   w_fsm_nxt = S_IDLE;
         default:  w_fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetModule) begin
         r_fsm      <= S_IDLE;
         r_round    <= '0;
         r_keyready <= 1'b0;
         r_done     <= 1'b0;
         r_out      <= '0;
      end else begin
         r_fsm  <= w_fsm_nxt;
         r_done <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               if (w_key_acc) r_keyready <= 1'b0;
               if (w_key_acc || w_blk_acc) r_round <= 4'd1;
            end
            S_KEYEXP: begin
               if (r_round == 4'(NUM_ROUNDS)) begin
                  r_keyready <= 1'b1;
                  r_round    <= '0;
               end else begin
                  r_round <= r_round + 4'd1;
               end
            end
            S_ROUND: r_round <= w_last ? '0 : r_round + 4'(ROUNDS_PER_CYCLE);
            S_DONE: begin
               r_out  <= r_data;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      case (r_fsm)
         S_IDLE: begin
            if (w_key_acc) r_rk[0] <= key;
            if (w_blk_acc) begin
               r_data <= inputData;
               r_dec  <= DEC_EN && modeDecrypt;
            end
         end
         S_KEYEXP: r_rk[r_round] <= w_next_key;
         S_INIT:   r_data <= r_data ^ (r_dec ? r_rk[NUM_ROUNDS] : r_rk[0]);
         S_ROUND:  r_data <= w_round_out;
         default: ;
      endcase
   end

   assign readyFlag    = (r_fsm == S_IDLE) && r_keyready;
   assign keyReadyFlag = r_keyready;
   assign outputData   = r_out;
   assign dataDoneFlag = r_done;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors on 1- and 2-round-per-cycle builds,
// plus key-expansion timing, back-to-back, reset-abort and dropped-request sequences.
module tb_aes_cipher_iter;

   localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   typedef struct {
      logic [127:0] k;
      logic [127:0] din;
      logic         dec;
      logic [127:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst, keyLoadFlag, modeDecrypt, inputsLoadedFlag;
   logic [127:0] key, inputData;
   logic         rdy1, krdy1, done1, rdy2, krdy2, done2;
   logic [127:0] out1, out2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   aes_cipher_iter #(.ROUNDS_PER_CYCLE(1), .DEC_EN(1'b1)) dut1 (
      .clock(clk), .resetModule(rst), .key(key), .keyLoadFlag(keyLoadFlag),
      .inputData(inputData), .modeDecrypt(modeDecrypt), .inputsLoadedFlag(inputsLoadedFlag),
      .readyFlag(rdy1), .keyReadyFlag(krdy1), .outputData(out1), .dataDoneFlag(done1));

   aes_cipher_iter #(.ROUNDS_PER_CYCLE(2), .DEC_EN(1'b1)) dut2 (
      .clock(clk), .resetModule(rst), .key(key), .keyLoadFlag(keyLoadFlag),
      .inputData(inputData), .modeDecrypt(modeDecrypt), .inputsLoadedFlag(inputsLoadedFlag),
      .readyFlag(rdy2), .keyReadyFlag(krdy2), .outputData(out2), .dataDoneFlag(done2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      key = k;
      keyLoadFlag = 1'b1;
      tick();
      keyLoadFlag = 1'b0;
      chk("keyexp_ready_low", 128'(rdy1), 128'(0));
      chk("keyexp_krdy_low", 128'(krdy1), 128'(0));
      repeat (9) tick();
      chk("keyexp_krdy_edge9", 128'(krdy1), 128'(0));
      tick();
      chk("keyexp_krdy_edge10", 128'(krdy1), 128'(1));
      chk("keyexp_ready_edge10", 128'(rdy1), 128'(1));
      chk("keyexp2_krdy_edge10", 128'(krdy2), 128'(1));
   endtask

   // Issues one block; kl_cyc > 0 pulses keyLoadFlag with a junk key on that edge.
   task automatic run_block(input string tag, input logic [127:0] din, input logic dec,
                            input logic [127:0] exp, input int kl_cyc);
      int lat1, lat2;
      lat1 = -1;
      lat2 = -1;
      inputData = din;
      modeDecrypt = dec;
      inputsLoadedFlag = 1'b1;
      tick();
      inputsLoadedFlag = 1'b0;
      chk({tag, "_ready_low"}, 128'(rdy1), 128'(0));
      for (int cyc = 1; cyc <= 20; cyc++) begin
         keyLoadFlag = (cyc == kl_cyc);
         if (cyc == kl_cyc) key = ~key;
         tick();
         if (done1 && lat1 < 0) lat1 = cyc;
         if (done2 && lat2 < 0) lat2 = cyc;
      end
      keyLoadFlag = 1'b0;
      chk({tag, "_out_r1"}, out1, exp);
      chk({tag, "_out_r2"}, out2, exp);
      chk({tag, "_lat_r1"}, 128'(lat1), 128'(12));
      chk({tag, "_lat_r2"}, 128'(lat2), 128'(7));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs [4];
      int   cnt, cnt2;
      int   pos1 [$];

      vecs[0] = '{k: K1, din: P1, dec: 1'b0, exp: C1};
      vecs[1] = '{k: K1, din: C1, dec: 1'b1, exp: P1};
      vecs[2] = '{k: K2, din: C2, dec: 1'b1, exp: P2};
      vecs[3] = '{k: K2, din: P2, dec: 1'b0, exp: C2};

      rst = 1'b1;
      key = '0;
      keyLoadFlag = 1'b0;
      inputData = '0;
      modeDecrypt = 1'b0;
      inputsLoadedFlag = 1'b0;
      repeat (3) tick();
      chk("reset_out", out1, '0);
      chk("reset_done", 128'(done1), 128'(0));
      chk("reset_krdy", 128'(krdy1), 128'(0));
      chk("reset_ready", 128'(rdy1), 128'(0));
      rst = 1'b0;
      tick();

      // Block request with no key expanded is dropped.
      inputData = P1;
      inputsLoadedFlag = 1'b1;
      cnt = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         if (done1 || done2) cnt++;
      end
      inputsLoadedFlag = 1'b0;
      chk("nokey_done_count", 128'(cnt), 128'(0));
      chk("nokey_ready", 128'(rdy1), 128'(0));

      for (int i = 0; i < 4; i++) begin
         load_key(vecs[i].k);
         run_block($sformatf("vec%0d", i), vecs[i].din, vecs[i].dec, vecs[i].exp, 0);
      end
      chk("rk10_r1", dut1.r_rk[10], RK10);
      chk("rk10_r2", dut2.r_rk[10], RK10);

      // keyLoadFlag and inputsLoadedFlag together: key wins, block dropped.
      key = K1;
      inputData = P2;
      keyLoadFlag = 1'b1;
      inputsLoadedFlag = 1'b1;
      tick();
      keyLoadFlag = 1'b0;
      inputsLoadedFlag = 1'b0;
      chk("both_krdy_low", 128'(krdy1), 128'(0));
      cnt = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         tick();
         if (done1 || done2) cnt++;
      end
      chk("both_done_count", 128'(cnt), 128'(0));
      chk("both_krdy_after", 128'(krdy1), 128'(1));
      run_block("after_both", P1, 1'b0, C1, 0);

      // keyLoadFlag mid-block must not disturb the round keys.
      run_block("midkey", P1, 1'b0, C1, 5);
      chk("midkey_krdy", 128'(krdy1), 128'(1));
      key = K1;

      // Held-high request: a new block on every IDLE visit.
      inputData = P1;
      modeDecrypt = 1'b0;
      inputsLoadedFlag = 1'b1;
      cnt2 = 0;
      for (int cyc = 0; cyc <= 50; cyc++) begin
         tick();
         if (done1) pos1.push_back(cyc);
         if (done2) cnt2++;
         if (cyc == 26) inputsLoadedFlag = 1'b0;
      end
      chk("held_count_r1", 128'(pos1.size()), 128'(3));
      for (int k = 0; k < 3; k++)
         chk($sformatf("held_pos%0d", k), 128'((pos1.size() > k) ? pos1[k] : -1),
             128'(12 + 13 * k));
      chk("held_count_r2", 128'(cnt2), 128'(4));
      chk("held_out", out1, C1);

      // Reset during round 5 aborts the block and invalidates the key.
      inputData = P1;
      inputsLoadedFlag = 1'b1;
      tick();
      inputsLoadedFlag = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      inputsLoadedFlag = 1'b1;
      cnt = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         if (done1 || done2) cnt++;
      end
      inputsLoadedFlag = 1'b0;
      chk("abort_done_count", 128'(cnt), 128'(0));
      chk("abort_out_r1", out1, '0);
      chk("abort_out_r2", out2, '0);
      chk("abort_ready", 128'(rdy1), 128'(0));
      chk("abort_krdy", 128'(krdy1), 128'(0));
      load_key(K1);
      run_block("post_abort", C1, 1'b1, P1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
